// File: rtl/piso_serial_tx.sv
// Parallel-in serial-out frame transmitter: start bit (0), WIDTH data bits LSB first,
// stop bit (1), each bit held for DIV enabled clock cycles.
module piso_serial_tx #(
    parameter int WIDTH = 8,
    parameter int DIV   = 4
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    output logic             sout,
    output logic             busy,
    output logic             done,
    output logic [1:0]       dbg_state
);

    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [BIT_W-1:0] bit_q, bit_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             sout_q, sout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             accept;
    logic             div_end;

    // Handshake: a word moves on a rising edge where load_valid && load_ready.
    // load_ready is only ever high in IDLE with en=1 and clr=0, so offers made
    // while a frame is running are simply not taken.
    assign load_ready = (state_q == IDLE) && en && !clr;
    assign accept     = load_valid && load_ready;
    assign div_end    = (div_q == DIV_LAST);

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        bit_d   = bit_q;
        div_d   = div_q;
        sout_d  = sout_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        if (en) begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_d = START;
                        shift_d = load_data;
                        bit_d   = '0;
                        div_d   = '0;
                        sout_d  = 1'b0;
                        busy_d  = 1'b1;
                    end
                end
                START: begin
                    if (div_end) begin
                        state_d = DATA;
                        div_d   = '0;
                        bit_d   = '0;
                        sout_d  = shift_q[0];
                    end else begin
                        div_d = div_q + 1'b1;
                    end
                end
                DATA: begin
                    if (div_end) begin
                        div_d   = '0;
                        shift_d = shift_q >> 1;
                        if (bit_q == BIT_LAST) begin
                            state_d = STOP;
                            sout_d  = 1'b1;
                        end else begin
                            bit_d  = bit_q + 1'b1;
                            sout_d = shift_d[0];
                        end
                    end else begin
                        div_d = div_q + 1'b1;
                    end
                end
                STOP: begin
                    // done is raised as IDLE is re-entered so the next accept can follow at once.
                    if (div_end) begin
                        state_d = IDLE;
                        div_d   = '0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        div_d = div_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= IDLE;
            shift_q <= '0;
            bit_q   <= '0;
            div_q   <= '0;
            sout_q  <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            bit_q   <= bit_d;
            div_q   <= div_d;
            sout_q  <= sout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign sout      = sout_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign dbg_state = state_q;

endmodule
